// File: rtl/input_fifo_pkg.sv
// Shared NoC router parameters: flit geometry and the not-routed code,
// used by every router stage.
package input_fifo_pkg;

   localparam int unsigned NOC_DATA_WIDTH = 8;
   localparam int unsigned NOC_DEPTH      = 4;
   localparam int unsigned NOC_ADDR_WIDTH = 2;

   localparam logic [2:0]  NOC_NOT_ROUTED = 3'b111;

endpackage

// File: rtl/input_fifo_mem.sv
// Flit storage for input_fifo: register array with a synchronous write port
// and an asynchronous read port. Contents are not reset.
module fifo_mem #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned DEPTH      = 4,
   parameter int unsigned ADDR_WIDTH = 2
) (
   input  logic                  clk,
   input  logic                  i_we,
   input  logic [ADDR_WIDTH-1:0] i_waddr,
   input  logic [DATA_WIDTH-1:0] i_wdata,
   input  logic [ADDR_WIDTH-1:0] i_raddr,
   output logic [DATA_WIDTH-1:0] o_rdata
);

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];

   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/input_fifo.sv
// Router input-port FIFO: first-word-fall-through flit buffer with an
// occupancy count, registered full/empty flags and a sticky overflow flag.
module input_fifo
   import input_fifo_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = NOC_DATA_WIDTH,
   parameter int unsigned DEPTH      = NOC_DEPTH,
   parameter int unsigned ADDR_WIDTH = NOC_ADDR_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] Data_in,
   input  logic                  write,
   output logic                  full,
   output logic [DATA_WIDTH-1:0] Data_out,
   input  logic                  read,
   output logic                  empty,
   output logic [ADDR_WIDTH:0]   count,
   output logic                  overflow
);

   localparam logic [ADDR_WIDTH:0]   C_FULL    = (ADDR_WIDTH+1)'(DEPTH);
   localparam logic [ADDR_WIDTH-1:0] C_PTR_ONE = ADDR_WIDTH'(1);
   localparam logic [ADDR_WIDTH:0]   C_CNT_ONE = (ADDR_WIDTH+1)'(1);

   logic [ADDR_WIDTH-1:0] r_wptr;
   logic [ADDR_WIDTH-1:0] r_rptr;
   logic [ADDR_WIDTH:0]   r_count;
   logic                  r_overflow;

   logic                  w_full;
   logic                  w_empty;
   logic                  w_push;
   logic                  w_pop;
   logic [DATA_WIDTH-1:0] w_rdata;

   // Flags decode straight from the registered count, so they only move on clk.
   assign w_full  = (r_count == C_FULL);
   assign w_empty = (r_count == '0);
   assign w_push  = write & ~w_full;
   assign w_pop   = read & ~w_empty;

   fifo_mem #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_mem (
      .clk     (clk),
      .i_we    (w_push),
      .i_waddr (r_wptr),
      .i_wdata (Data_in),
      .i_raddr (r_rptr),
      .o_rdata (w_rdata)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wptr     <= '0;
         r_rptr     <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_push) begin
            r_wptr <= r_wptr + C_PTR_ONE;
         end
         if (w_pop) begin
            r_rptr <= r_rptr + C_PTR_ONE;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + C_CNT_ONE;
            2'b01:   r_count <= r_count - C_CNT_ONE;
            default: r_count <= r_count;
         endcase
         if (write && w_full) begin
            r_overflow <= 1'b1;
         end
      end
   end

   assign full     = w_full;
   assign empty    = w_empty;
   assign count    = r_count;
   assign overflow = r_overflow;
   assign Data_out = w_empty ? '0 : w_rdata;

endmodule

// File: tb/tb_input_fifo.sv
// Self-checking bench for input_fifo: directed scenarios plus random traffic,
// compared against a queue-based reference model.
module tb_input_fifo;

   localparam int unsigned DW    = 8;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned AW    = 2;

   logic          clk;
   logic          rst;
   logic [DW-1:0] Data_in;
   logic          write;
   logic          full;
   logic [DW-1:0] Data_out;
   logic          read;
   logic          empty;
   logic [AW:0]   count;
   logic          overflow;

   int unsigned n_cmp;
   int unsigned n_err;

   logic [DW-1:0] m_q[$];
   bit            m_ovf;

   input_fifo #(
      .DATA_WIDTH (DW),
      .DEPTH      (DEPTH),
      .ADDR_WIDTH (AW)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .Data_in  (Data_in),
      .write    (write),
      .full     (full),
      .Data_out (Data_out),
      .read     (read),
      .empty    (empty),
      .count    (count),
      .overflow (overflow)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag);
      logic [31:0] exp_head;
      exp_head = (m_q.size() == 0) ? 32'h0 : 32'(m_q[0]);
      chk({tag, ".count"},    32'(count),    32'(m_q.size()));
      chk({tag, ".empty"},    32'(empty),    32'(m_q.size() == 0));
      chk({tag, ".full"},     32'(full),     32'(m_q.size() == DEPTH));
      chk({tag, ".data"},     32'(Data_out), exp_head);
      chk({tag, ".overflow"}, 32'(overflow), 32'(m_ovf));
   endtask

   // Apply one cycle of stimulus; the model decides from the pre-edge occupancy.
   task automatic step(input string tag, input bit w, input bit r, input logic [DW-1:0] d);
      bit do_push;
      bit do_pop;
      write   = w;
      read    = r;
      Data_in = d;
      do_push = w && (m_q.size() < DEPTH);
      do_pop  = r && (m_q.size() > 0);
      if (w && m_q.size() == DEPTH) m_ovf = 1'b1;
      @(posedge clk);
      if (do_pop)  void'(m_q.pop_front());
      if (do_push) m_q.push_back(d);
      #1;
      write = 1'b0;
      read  = 1'b0;
      chk_all(tag);
   endtask

   task automatic model_reset();
      m_q.delete();
      m_ovf = 1'b0;
   endtask

   initial begin
      n_cmp   = 0;
      n_err   = 0;
      rst     = 1'b1;
      write   = 1'b0;
      read    = 1'b0;
      Data_in = '0;
      model_reset();
      #2;
      chk_all("reset");
      @(posedge clk);
      #1;
      rst = 1'b0;
      chk_all("reset_release");

      // Single push visible one cycle later
      step("push35", 1, 0, 8'h35);
      chk("push35.value", 32'(Data_out), 32'h35);
      step("pop35", 0, 1, 8'h00);
      step("read_empty", 0, 1, 8'h00);

      // Fill, overflow, drain
      for (int i = 1; i <= 4; i++) step("fill", 1, 0, 8'(i));
      chk("fill.full", 32'(full), 32'h1);
      step("push_over", 1, 0, 8'h05);
      chk("push_over.overflow", 32'(overflow), 32'h1);
      for (int i = 1; i <= 4; i++) begin
         chk("drain.head", 32'(Data_out), 32'(i));
         step("drain", 0, 1, 8'h00);
      end
      chk("drain.data_zero", 32'(Data_out), 32'h0);

      // Steady state at count=2 across pointer wrap
      step("ss_a", 1, 0, 8'h10);
      step("ss_b", 1, 0, 8'h11);
      for (int i = 0; i < 10; i++) step("steady", 1, 1, 8'(8'h20 + i));
      chk("steady.count", 32'(count), 32'h2);
      step("ss_d1", 0, 1, 8'h00);
      step("ss_d2", 0, 1, 8'h00);

      // Simultaneous write/read while empty
      step("empty_wr", 1, 1, 8'hA6);
      chk("empty_wr.value", 32'(Data_out), 32'hA6);
      step("empty_wr_pop", 0, 1, 8'h00);

      // Simultaneous write/read while full
      for (int i = 0; i < 4; i++) step("refill", 1, 0, 8'(8'h40 + i));
      step("full_wr", 1, 1, 8'h99);
      chk("full_wr.count", 32'(count), 32'h3);
      chk("full_wr.head", 32'(Data_out), 32'h41);

      // Asynchronous reset between edges with count=3
      #2;
      rst = 1'b1;
      model_reset();
      #1;
      chk_all("async_rst");
      write   = 1'b1;
      read    = 1'b1;
      Data_in = 8'h77;
      @(posedge clk);
      #1;
      chk_all("rst_hold");
      write = 1'b0;
      read  = 1'b0;
      rst   = 1'b0;
      step("post_rst_push", 1, 0, 8'h0F);
      chk("post_rst_push.value", 32'(Data_out), 32'h0F);
      step("post_rst_pop", 0, 1, 8'h00);

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         step("rand", ($urandom_range(0, 99) < 55), ($urandom_range(0, 99) < 45),
              8'($urandom));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/input_fifo.md
INPUT_FIFO -- requirements
Module: input_fifo

Interface
REQ-001 Parameter DATA_WIDTH, default 8: flit width in bits.
REQ-002 Parameter DEPTH, default 4: number of flit entries; SHALL be a power of two, at least 2.
REQ-003 Parameter ADDR_WIDTH, default 2: pointer width; SHALL equal log2(DEPTH).
REQ-004 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 Data_in  input  DATA_WIDTH  flit from the link or neighbouring router.
REQ-007 write  input  1  Data_in is valid this cycle; push request.
REQ-008 full  output  1  no free entry; upstream SHALL NOT rely on a push while high.
REQ-009 Data_out  output  DATA_WIDTH  head flit, first-word-fall-through; feeds the input controller Data_in.
REQ-010 read  input  1  pop request; driven by the input controller (empty low and grant high).
REQ-011 empty  output  1  no valid entry; feeds the input controller empty.
REQ-012 count  output  ADDR_WIDTH+1  number of stored flits, 0..DEPTH.
REQ-013 overflow  output  1  sticky flag: a push was attempted while full.

Function
REQ-014 A push SHALL occur on a rising edge when write=1 and full=0: Data_in is stored at the write pointer, and the write pointer increments modulo DEPTH.
REQ-015 A pop SHALL occur on a rising edge when read=1 and empty=0: the read pointer increments modulo DEPTH.
REQ-016 write=1 with full=1 SHALL be dropped, leave storage and pointers unchanged, and set overflow=1.
REQ-017 read=1 with empty=1 SHALL be ignored, with no state change and no error.
REQ-018 A simultaneous push and pop with 0<count<DEPTH SHALL both occur, leaving count unchanged.
REQ-019 A simultaneous write and read when full: the pop SHALL occur and the write SHALL be dropped, per REQ-016; full deasserts next cycle.
REQ-020 A simultaneous write and read when empty: the push SHALL occur and the read SHALL be ignored; empty deasserts next cycle.
REQ-021 Data_out SHALL be combinationally the entry at the read pointer when empty=0, and 0 when empty=1. Push-to-visible latency is 1 cycle.
REQ-022 empty SHALL equal (count==0) and full SHALL equal (count==DEPTH); both SHALL be registered-state derived and glitch-free relative to clk.
REQ-023 count SHALL increment on a push only, decrement on a pop only, and SHALL NOT wrap.
REQ-024 Pointer wrap from DEPTH-1 to 0 SHALL preserve FIFO order.
REQ-025 Flit content SHALL pass unmodified; address bits [3:0] are not interpreted here.

Reset
REQ-026 While rst=1, regardless of clk: pointers=0, count=0, empty=1, full=0, Data_out=0, overflow=0.
REQ-027 Reset asserted mid-operation SHALL discard all stored flits; storage contents need not be cleared.
REQ-028 write and read SHALL have no effect while rst=1; the first push is accepted on the first rising edge after release.

Structure
REQ-029 DATA_WIDTH, DEPTH, ADDR_WIDTH defaults and the not-routed code 3'b111 SHALL live in the shared NoC parameter include, used by all router stages.
REQ-030 Storage SHALL be one sub-module, fifo_mem: a register array with a synchronous write port and an asynchronous read port. Pointer, count and flag logic SHALL stay in input_fifo.

Verification
REQ-031 Reset, then write 8'h35 for one cycle -> next cycle empty=0, Data_out=8'h35, count=1.
REQ-032 Push 8'h01,8'h02,8'h03,8'h04 -> full=1, count=4; a fifth push 8'h05 -> dropped, overflow=1; four pops -> outputs 01,02,03,04, then empty=1, Data_out=0.
REQ-033 Steady state at count=2: write and read every cycle for 10 cycles -> count stays 2, output order matches input order across pointer wrap.
REQ-034 Empty FIFO: write=1 and read=1 with Data_in=8'hA6 -> flit retained, empty=0, Data_out=8'hA6 next cycle.
REQ-035 Full FIFO with write=1 and read=1 -> count=3, head advances, overflow=1.
REQ-036 Assert rst asynchronously between edges with count=3 -> immediately empty=1, count=0, Data_out=0; after release, 8'h0F pushes and pops normally.
